// File: rtl/ahb_decode_resp_mux_if.sv
// Bus bundle for the AHB-Lite decode / response-mux stage.
// master : environment view (drives address phase and slave responses,
//          observes selects, muxed response and watchdog status).
// slave  : interconnect view, used by ahb_decode_resp_mux.
interface ahb_decode_resp_mux_if #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Master address phase
    logic [ADDR_WIDTH-1:0]            HADDR;
    logic [1:0]                       HTRANS;
    // Address-phase selects
    logic [NUM_SLAVES-1:0]            HSEL;
    logic                             HSEL_DEFAULT;
    // Slave responses, packed by slave index
    logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s;
    logic [NUM_SLAVES-1:0]            hready_s;
    logic [2*NUM_SLAVES-1:0]          hresp_s;
    logic [DATA_WIDTH-1:0]            hrdata_default;
    logic                             hready_default;
    logic [1:0]                       hresp_default;
    // Muxed response back to the master
    logic [DATA_WIDTH-1:0]            HRDATA;
    logic                             HREADY;
    logic [1:0]                       HRESP;
    // Watchdog status
    logic                             timeout_clr;
    logic                             timeout_irq;
    logic [7:0]                       timeout_cnt;

    modport master (
        output HADDR, HTRANS,
        output hrdata_s, hready_s, hresp_s,
        output hrdata_default, hready_default, hresp_default,
        output timeout_clr,
        input  HSEL, HSEL_DEFAULT,
        input  HRDATA, HREADY, HRESP,
        input  timeout_irq, timeout_cnt
    );

    modport slave (
        input  HADDR, HTRANS,
        input  hrdata_s, hready_s, hresp_s,
        input  hrdata_default, hready_default, hresp_default,
        input  timeout_clr,
        output HSEL, HSEL_DEFAULT,
        output HRDATA, HREADY, HRESP,
        output timeout_irq, timeout_cnt
    );
endinterface

// File: rtl/ahb_decode_resp_mux.sv
// AHB-Lite decode and response-mux stage with a wait-state watchdog.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus           : ahb_decode_resp_mux_if.slave
//                   address phase in, HSEL/HSEL_DEFAULT out,
//                   slave + default-slave responses in,
//                   HRDATA/HREADY/HRESP out,
//                   timeout_clr in, timeout_irq/timeout_cnt out
module ahb_decode_resp_mux #(
    parameter int unsigned                      NUM_SLAVES     = 3,
    parameter int unsigned                      ADDR_WIDTH     = 32,
    parameter int unsigned                      DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE     =
        {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK     = {3{32'hF000_0000}},
    parameter int unsigned                      TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_decode_resp_mux_if.slave  bus
);

    localparam int unsigned          SEL_W       = $clog2(NUM_SLAVES + 1);
    localparam logic [SEL_W-1:0]     SEL_DEFAULT = SEL_W'(NUM_SLAVES);
    localparam logic [7:0]           WAIT_LIMIT  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]           RESP_OKAY   = 2'b00;
    localparam logic [1:0]           RESP_ERROR  = 2'b01;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ERR1   = 2'd1,
        ST_ERR2   = 2'd2
    } state_t;

    state_t                  state;
    logic [SEL_W-1:0]        sel_q;
    logic                    valid_q;
    logic [7:0]              wait_cnt;
    logic                    irq_q;
    logic [7:0]              abort_cnt;

    logic [SEL_W-1:0]        dec_idx;
    logic [NUM_SLAVES-1:0]   hsel;
    logic [DATA_WIDTH-1:0]   src_rdata;
    logic                    src_ready;
    logic [1:0]              src_resp;
    logic [DATA_WIDTH-1:0]   hrdata_c;
    logic                    hready_c;
    logic [1:0]              hresp_c;
    logic                    stall;
    logic                    abort;

    // Address decode: scan downward so the lowest matching index wins.
    always_comb begin
        dec_idx = SEL_DEFAULT;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((bus.HADDR & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_idx = SEL_W'(i);
            end
        end
    end

    // One-hot select from the winning index.
    always_comb begin
        hsel = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            hsel[i] = (dec_idx == SEL_W'(i));
        end
    end

    // Response source for the current data-phase owner.
    always_comb begin
        src_rdata = bus.hrdata_default;
        src_ready = bus.hready_default;
        src_resp  = bus.hresp_default;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (sel_q == SEL_W'(i)) begin
                src_rdata = bus.hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
                src_ready = bus.hready_s[i];
                src_resp  = bus.hresp_s[2*i +: 2];
            end
        end
    end

    // Response mux; ERR states override the slave with a two-cycle ERROR.
    always_comb begin
        hrdata_c = '0;
        hready_c = 1'b1;
        hresp_c  = RESP_OKAY;
        case (state)
            ST_NORMAL: begin
                if (valid_q) begin
                    hrdata_c = src_rdata;
                    hready_c = src_ready;
                    hresp_c  = src_resp;
                end
            end
            ST_ERR1: begin
                hready_c = 1'b0;
                hresp_c  = RESP_ERROR;
            end
            ST_ERR2: begin
                hresp_c  = RESP_ERROR;
            end
            default: begin
                hready_c = 1'b1;
            end
        endcase
    end

    // A ready slave at the threshold completes normally (stall is false).
    assign stall = (state == ST_NORMAL) && valid_q && !src_ready;
    assign abort = stall && (wait_cnt == WAIT_LIMIT);

    // Data-phase register, watchdog FSM and status counters.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_NORMAL;
            sel_q     <= SEL_DEFAULT;
            valid_q   <= 1'b0;
            wait_cnt  <= '0;
            irq_q     <= 1'b0;
            abort_cnt <= '0;
        end else begin
            if (hready_c) begin
                sel_q   <= dec_idx;
                valid_q <= bus.HTRANS[1];
            end

            case (state)
                ST_NORMAL: if (abort) state <= ST_ERR1;
                ST_ERR1:   state <= ST_ERR2;
                ST_ERR2:   state <= ST_NORMAL;
                default:   state <= ST_NORMAL;
            endcase

            wait_cnt <= (stall && !abort) ? wait_cnt + 8'd1 : 8'd0;

            // A new abort wins over a simultaneous clear.
            if (abort) begin
                irq_q <= 1'b1;
            end else if (bus.timeout_clr) begin
                irq_q <= 1'b0;
            end

            if (abort && (abort_cnt != 8'hFF)) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end

    assign bus.HSEL         = hsel;
    assign bus.HSEL_DEFAULT = ~|hsel;
    assign bus.HRDATA       = hrdata_c;
    assign bus.HREADY       = hready_c;
    assign bus.HRESP        = hresp_c;
    assign bus.timeout_irq  = irq_q;
    assign bus.timeout_cnt  = abort_cnt;

endmodule

// File: tb/tb_ahb_decode_resp_mux.sv
// Directed bench for ahb_decode_resp_mux: decode, mux, wait states,
// watchdog abort, irq clear/priority and asynchronous reset in ERR1.
module tb_ahb_decode_resp_mux;

    localparam logic [31:0] D0   = 32'h1111_0000;
    localparam logic [31:0] D1   = 32'hCAFE_F00D;
    localparam logic [31:0] D2   = 32'h2222_0000;
    localparam logic [31:0] DDEF = 32'hDEAD_0000;

    logic HCLK;
    logic HRESETn;
    int   n_cmp;
    int   n_err;

    ahb_decode_resp_mux_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_decode_resp_mux dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        HRESETn                = 1'b0;
        bus.HADDR              = 32'h0;
        bus.HTRANS             = 2'b00;
        bus.hrdata_s           = {D2, D1, D0};
        bus.hready_s           = 3'b111;
        bus.hresp_s            = 6'b0;
        bus.hrdata_default     = DDEF;
        bus.hready_default     = 1'b1;
        bus.hresp_default      = 2'b00;
        bus.timeout_clr        = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        settle();

        // Reset release, IDLE
        chk("rst_hready", 32'(bus.HREADY), 32'd1);
        chk("rst_hresp", 32'(bus.HRESP), 32'd0);
        chk("rst_hrdata", bus.HRDATA, 32'd0);
        chk("rst_tcnt", 32'(bus.timeout_cnt), 32'd0);
        chk("rst_irq", 32'(bus.timeout_irq), 32'd0);

        // NONSEQ to slave1
        bus.HADDR  = 32'h1000_0040;
        bus.HTRANS = 2'b10;
        settle();
        chk("s1_hsel", 32'(bus.HSEL), 32'b010);
        chk("s1_hseldef", 32'(bus.HSEL_DEFAULT), 32'd0);
        tick();
        bus.HADDR  = 32'h0;
        bus.HTRANS = 2'b00;
        settle();
        chk("s1_hrdata", bus.HRDATA, D1);
        chk("s1_hready", 32'(bus.HREADY), 32'd1);
        chk("s1_hresp", 32'(bus.HRESP), 32'd0);
        chk("s0_hsel_idle", 32'(bus.HSEL), 32'b001);

        // Unmapped address to default slave returning ERROR
        bus.HADDR         = 32'h5000_0000;
        bus.HTRANS        = 2'b10;
        bus.hresp_default = 2'b01;
        settle();
        chk("def_hsel", 32'(bus.HSEL), 32'b000);
        chk("def_hseldef", 32'(bus.HSEL_DEFAULT), 32'd1);
        tick();
        bus.HADDR  = 32'h0;
        bus.HTRANS = 2'b00;
        settle();
        chk("def_hresp", 32'(bus.HRESP), 32'b01);
        chk("def_hrdata", bus.HRDATA, DDEF);
        tick();
        settle();
        chk("idle_hresp", 32'(bus.HRESP), 32'd0);
        chk("idle_hrdata", bus.HRDATA, 32'd0);
        bus.hresp_default = 2'b00;

        // BUSY is not a transfer
        bus.HADDR  = 32'h1000_0000;
        bus.HTRANS = 2'b01;
        tick();
        bus.HTRANS = 2'b00;
        settle();
        chk("busy_hrdata", bus.HRDATA, 32'd0);

        // Slave0 with three wait states
        bus.HADDR  = 32'h0000_0100;
        bus.HTRANS = 2'b10;
        tick();
        bus.HADDR     = 32'h0;
        bus.HTRANS    = 2'b00;
        bus.hready_s  = 3'b110;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("ws_hready%0d", i), 32'(bus.HREADY), 32'd0);
            tick();
        end
        bus.hready_s = 3'b111;
        settle();
        chk("ws_done_hready", 32'(bus.HREADY), 32'd1);
        chk("ws_done_hrdata", bus.HRDATA, D0);
        chk("ws_done_hresp", 32'(bus.HRESP), 32'd0);
        chk("ws_irq", 32'(bus.timeout_irq), 32'd0);
        tick();

        // Slave2 stuck: 16 wait cycles, then ERR1, ERR2
        bus.HADDR  = 32'h2000_0000;
        bus.HTRANS = 2'b10;
        tick();
        bus.HADDR    = 32'h0;
        bus.HTRANS   = 2'b00;
        bus.hready_s = 3'b011;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk($sformatf("to_wait%0d", i), 32'(bus.HREADY), 32'd0);
            tick();
        end
        // ERR1: slave ready now high but must be ignored
        bus.hready_s = 3'b111;
        bus.HADDR    = 32'h0000_0200;
        bus.HTRANS   = 2'b10;
        settle();
        chk("err1_hready", 32'(bus.HREADY), 32'd0);
        chk("err1_hresp", 32'(bus.HRESP), 32'b01);
        chk("err1_hrdata", bus.HRDATA, 32'd0);
        chk("err1_irq", 32'(bus.timeout_irq), 32'd1);
        chk("err1_tcnt", 32'(bus.timeout_cnt), 32'd1);
        tick();
        settle();
        chk("err2_hready", 32'(bus.HREADY), 32'd1);
        chk("err2_hresp", 32'(bus.HRESP), 32'b01);
        tick();
        bus.HADDR  = 32'h0;
        bus.HTRANS = 2'b00;
        settle();
        chk("post_hrdata", bus.HRDATA, D0);
        chk("post_hresp", 32'(bus.HRESP), 32'd0);
        chk("post_hready", 32'(bus.HREADY), 32'd1);

        // Clear irq, count stays
        bus.timeout_clr = 1'b1;
        tick();
        bus.timeout_clr = 1'b0;
        settle();
        chk("clr_irq", 32'(bus.timeout_irq), 32'd0);
        chk("clr_tcnt", 32'(bus.timeout_cnt), 32'd1);

        // Ready rises exactly at the threshold cycle: normal completion
        bus.HADDR  = 32'h2000_0000;
        bus.HTRANS = 2'b10;
        tick();
        bus.HADDR    = 32'h0;
        bus.HTRANS   = 2'b00;
        bus.hready_s = 3'b011;
        for (int i = 0; i < 15; i++) tick();
        bus.hready_s = 3'b111;
        settle();
        chk("thr_hready", 32'(bus.HREADY), 32'd1);
        chk("thr_hresp", 32'(bus.HRESP), 32'd0);
        chk("thr_hrdata", bus.HRDATA, D2);
        tick();
        settle();
        chk("thr_irq", 32'(bus.timeout_irq), 32'd0);
        chk("thr_tcnt", 32'(bus.timeout_cnt), 32'd1);

        // Abort with simultaneous clear, then reset in ERR1
        bus.HADDR  = 32'h2000_0000;
        bus.HTRANS = 2'b10;
        tick();
        bus.HADDR    = 32'h0;
        bus.HTRANS   = 2'b00;
        bus.hready_s = 3'b011;
        for (int i = 0; i < 15; i++) tick();
        bus.timeout_clr = 1'b1;
        tick();
        bus.timeout_clr = 1'b0;
        settle();
        chk("clrab_irq", 32'(bus.timeout_irq), 32'd1);
        chk("clrab_tcnt", 32'(bus.timeout_cnt), 32'd2);
        chk("clrab_hresp", 32'(bus.HRESP), 32'b01);
        chk("clrab_hready", 32'(bus.HREADY), 32'd0);
        HRESETn = 1'b0;
        settle();
        chk("arst_hready", 32'(bus.HREADY), 32'd1);
        chk("arst_hresp", 32'(bus.HRESP), 32'd0);
        chk("arst_hrdata", bus.HRDATA, 32'd0);
        chk("arst_tcnt", 32'(bus.timeout_cnt), 32'd0);
        chk("arst_irq", 32'(bus.timeout_irq), 32'd0);
        bus.hready_s = 3'b111;
        tick();
        HRESETn = 1'b1;
        tick();
        settle();
        chk("rel_hready", 32'(bus.HREADY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
